// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - captures skewed systolic row bursts into per-row FIFOs and
// drains them round-robin onto one row-major addressed write port.
module systolic_drain #(
  parameter int D_W_ACC = 16,
  parameter int N1      = 2,
  parameter int N2      = 2,
  parameter int M       = 4,
  parameter int FIFO_D  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [D_W_ACC-1:0]     D [N1-1:0],
  input  logic [N1-1:0]          valid_D,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [$clog2(M*M)-1:0] wr_addr,
  output logic [D_W_ACC-1:0]     wr_data,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW  = $clog2(M*M);
  localparam int RT  = M / N1;
  localparam int NT  = (M / N1) * (M / N2);
  localparam int KW  = (N2 > 1) ? $clog2(N2) : 1;
  localparam int TW  = $clog2(NT + 1);
  localparam int PW  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW  = $clog2(FIFO_D + 1);
  localparam int RW  = (N1 > 1) ? $clog2(N1) : 1;
  localparam int WCW = $clog2(M*M + 1);
  localparam int EW  = AW + D_W_ACC;

  logic [KW-1:0]      k_q   [N1];
  logic [KW-1:0]      k_d   [N1];
  logic [TW-1:0]      t_q   [N1];
  logic [TW-1:0]      t_d   [N1];
  logic [PW-1:0]      wp_q  [N1];
  logic [PW-1:0]      wp_d  [N1];
  logic [PW-1:0]      rp_q  [N1];
  logic [PW-1:0]      rp_d  [N1];
  logic [CW-1:0]      cnt_q [N1];
  logic [CW-1:0]      cnt_d [N1];
  logic [EW-1:0]      mem_q [N1][FIFO_D];
  logic [EW-1:0]      mem_d [N1][FIFO_D];
  logic [RW-1:0]      start_q, start_d;
  logic [RW-1:0]      grant, cand;
  logic               found, load;
  logic [N1-1:0]      push, pop;
  logic               wr_valid_q, wr_valid_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [D_W_ACC-1:0] wr_data_q, wr_data_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  int                 addr_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_D - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    k_d        = k_q;
    t_d        = t_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    start_d    = start_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wcnt_d     = wcnt_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    push       = '0;
    pop        = '0;
    found      = 1'b0;
    grant      = '0;
    cand       = '0;
    addr_i     = 0;
    load       = !wr_valid_q || wr_ready;

    // Round-robin: first non-empty row at or after the row following the last grant
    for (int i = 0; i < N1; i++) begin
      cand = RW'((int'(start_q) + i) % N1);
      if (!found && cnt_q[cand] != '0) begin
        found = 1'b1;
        grant = cand;
      end
    end

    if (wr_valid_q && wr_ready) begin
      if (int'(wcnt_q) != M*M) wcnt_d = wcnt_q + 1'b1;
      if (int'(wcnt_q) == M*M - 1) done_d = 1'b1;
    end

    if (load) begin
      if (found) begin
        pop[grant]               = 1'b1;
        {wr_addr_d, wr_data_d}   = mem_q[grant][rp_q[grant]];
        wr_valid_d               = 1'b1;
        start_d                  = (int'(grant) == N1 - 1) ? '0 : grant + 1'b1;
      end else begin
        wr_valid_d = 1'b0;
      end
    end

    for (int x = 0; x < N1; x++) begin
      // Rows past the last tile are silent: no push, no overflow
      if (valid_D[x] && int'(t_q[x]) < NT) begin
        addr_i = ((int'(t_q[x]) % RT) * N1 + x) * M
               + (int'(t_q[x]) / RT) * N2 + (N2 - 1 - int'(k_q[x]));
        if (int'(cnt_q[x]) == FIFO_D) begin
          overflow_d = 1'b1;
        end else begin
          mem_d[x][wp_q[x]] = {AW'(addr_i), D[x]};
          wp_d[x]           = ptr_inc(wp_q[x]);
          push[x]           = 1'b1;
        end
        if (int'(k_q[x]) == N2 - 1) begin
          k_d[x] = '0;
          t_d[x] = t_q[x] + 1'b1;
        end else begin
          k_d[x] = k_q[x] + 1'b1;
        end
      end
      if (pop[x]) rp_d[x] = ptr_inc(rp_q[x]);
      case ({push[x], pop[x]})
        2'b10:   cnt_d[x] = cnt_q[x] + 1'b1;
        2'b01:   cnt_d[x] = cnt_q[x] - 1'b1;
        default: cnt_d[x] = cnt_q[x];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '{default: '0};
      t_q        <= '{default: '0};
      wp_q       <= '{default: '0};
      rp_q       <= '{default: '0};
      cnt_q      <= '{default: '0};
      start_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wcnt_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      t_q        <= t_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wcnt_q     <= wcnt_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the counters
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule
